sram_burst_ctrl: RTL and testbench

- Sequencer directly upstream of the dual-port sram block. It owns both SRAM ports.
- Fill phase: accepts a word stream and packs two consecutive words into each SRAM write.
- Drain phase: reads the burst back two words per handshake onto an output stream.
- Lets compute stages load and replay a buffer without driving SRAM addresses themselves.

---
 rtl/sram_burst_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_sram_burst_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_burst_ctrl.sv
// Burst sequencer for a dual-port SRAM: packs an input word stream into pair writes,
// then replays the burst as word pairs on an output stream.
module sram_burst_ctrl #(
    parameter int SIZE       = 300,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [ADDR_WIDTH-1:0] cfg_len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data1,
    output logic [DATA_WIDTH-1:0] out_data2,
    output logic                  out_two,
    output logic                  out_last,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr1,
    output logic [ADDR_WIDTH-1:0] mem_addr2,
    output logic [DATA_WIDTH-1:0] mem_din1,
    output logic [DATA_WIDTH-1:0] mem_din2,
    input  logic [DATA_WIDTH-1:0] mem_dout1,
    input  logic [DATA_WIDTH-1:0] mem_dout2
);

    localparam int CW = ADDR_WIDTH + 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FILL_A = 3'd1;
    localparam logic [2:0] FILL_B = 3'd2;
    localparam logic [2:0] FLUSH  = 3'd3;
    localparam logic [2:0] DRAIN  = 3'd4;
    localparam logic [2:0] FIN    = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic [ADDR_WIDTH-1:0] k_q, k_d;
    logic [ADDR_WIDTH-1:0] r_q, r_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  err_q, err_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr1_q, addr1_d;
    logic [ADDR_WIDTH-1:0] addr2_q, addr2_d;
    logic [DATA_WIDTH-1:0] din1_q, din1_d;
    logic [DATA_WIDTH-1:0] din2_q, din2_d;

    // Counts compared one bit wider so r+2 and base+len cannot overflow.
    logic [CW-1:0] len_ext, k_ext, r_ext, cfg_end;
    logic          in_hs, out_hs, drain, tail, last_pair;

    always_comb begin
        len_ext   = {1'b0, len_q};
        k_ext     = {1'b0, k_q};
        r_ext     = {1'b0, r_q};
        cfg_end   = {1'b0, cfg_base} + {1'b0, cfg_len};
        drain     = (state_q == DRAIN);
        tail      = ((r_ext + CW'(1)) >= len_ext);
        last_pair = ((r_ext + CW'(2)) >= len_ext);
        in_hs     = in_valid && in_ready;
        out_hs    = out_valid && out_ready;
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        k_d     = k_q;
        r_d     = r_q;
        hold_d  = hold_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr1_d = addr1_q;
        addr2_d = addr2_q;
        din1_d  = din1_q;
        din2_d  = din2_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d = cfg_base;
                    len_d  = cfg_len;
                    k_d    = '0;
                    if (cfg_len == '0) begin
                        err_d   = 1'b0;
                        state_d = FIN;
                    end else if (cfg_end > CW'(SIZE)) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else begin
                        err_d   = 1'b0;
                        state_d = FILL_A;
                    end
                end
            end
            FILL_A: begin
                if (in_hs) begin
                    if ((k_ext + CW'(1)) == len_ext) begin
                        we_d    = 1'b1;
                        addr1_d = base_q + k_q;
                        addr2_d = base_q + k_q;
                        din1_d  = in_data;
                        din2_d  = in_data;
                        state_d = FLUSH;
                    end else begin
                        hold_d  = in_data;
                        state_d = FILL_B;
                    end
                end
            end
            FILL_B: begin
                if (in_hs) begin
                    we_d    = 1'b1;
                    addr1_d = base_q + k_q;
                    addr2_d = base_q + k_q + ADDR_WIDTH'(1);
                    din1_d  = hold_q;
                    din2_d  = in_data;
                    k_d     = k_q + ADDR_WIDTH'(2);
                    state_d = ((k_ext + CW'(2)) == len_ext) ? FLUSH : FILL_A;
                end
            end
            FLUSH: begin
                // Pre-load the first read pair so DRAIN sees data on its first cycle.
                r_d     = '0;
                addr1_d = base_q;
                addr2_d = (len_q == ADDR_WIDTH'(1)) ? base_q : base_q + ADDR_WIDTH'(1);
                state_d = DRAIN;
            end
            DRAIN: begin
                if (out_hs) begin
                    r_d = r_q + ADDR_WIDTH'(2);
                    if (last_pair) begin
                        state_d = FIN;
                    end else begin
                        addr1_d = base_q + r_q + ADDR_WIDTH'(2);
                        addr2_d = ((r_ext + CW'(3)) == len_ext) ? base_q + r_q + ADDR_WIDTH'(2)
                                                                : base_q + r_q + ADDR_WIDTH'(3);
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            len_q   <= '0;
            k_q     <= '0;
            r_q     <= '0;
            hold_q  <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr1_q <= '0;
            addr2_q <= '0;
            din1_q  <= '0;
            din2_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            k_q     <= k_d;
            r_q     <= r_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr1_q <= addr1_d;
            addr2_q <= addr2_d;
            din1_q  <= din1_d;
            din2_q  <= din2_d;
        end
    end

    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == FIN);
        err       = done && err_q;
        in_ready  = (state_q == FILL_A) || (state_q == FILL_B);
        out_valid = drain;
        out_two   = drain && !tail;
        out_last  = drain && last_pair;
        out_data1 = drain ? mem_dout1 : '0;
        out_data2 = drain ? (tail ? mem_dout1 : mem_dout2) : '0;
        mem_we    = we_q;
        mem_addr1 = addr1_q;
        mem_addr2 = addr2_q;
        mem_din1  = din1_q;
        mem_din2  = din2_q;
    end

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Randomized scoreboard bench for sram_burst_ctrl with a behavioural SRAM and burst model.
module tb_sram_burst_ctrl;

    localparam int SIZE = 300;
    localparam int DW   = 32;
    localparam int AW   = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] cfg_base = '0;
    logic [AW-1:0] cfg_len = '0;
    logic          busy, done, err;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data1, out_data2;
    logic          out_two, out_last;
    logic          mem_we;
    logic [AW-1:0] mem_addr1, mem_addr2;
    logic [DW-1:0] mem_din1, mem_din2, mem_dout1, mem_dout2;

    always #5 clk = ~clk;

    sram_burst_ctrl #(.SIZE(SIZE), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_len(cfg_len),
        .busy(busy), .done(done), .err(err),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data1(out_data1),
        .out_data2(out_data2), .out_two(out_two), .out_last(out_last),
        .mem_we(mem_we), .mem_addr1(mem_addr1), .mem_addr2(mem_addr2),
        .mem_din1(mem_din1), .mem_din2(mem_din2), .mem_dout1(mem_dout1), .mem_dout2(mem_dout2)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr1] <= mem_din1;
            mem[mem_addr2] <= mem_din2;
        end
    end
    assign mem_dout1 = mem[mem_addr1];
    assign mem_dout2 = mem[mem_addr2];

    typedef struct {
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
    } wr_t;
    typedef struct {
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic          two;
        logic          last;
    } rd_t;

    wr_t  wr_q[$];
    rd_t  rd_q[$];
    logic done_q[$];

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Monitor: compares every write, output handshake and done pulse against the queues.
    wr_t           mw;
    rd_t           mr;
    logic          mdone;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] prev_d1, prev_d2;
    logic          prev_two, prev_last;

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (mem_we) begin
                if (wr_q.size() == 0) flag("unexpected_write");
                else begin
                    mw = wr_q.pop_front();
                    check("wr_addr1", 64'(mem_addr1), 64'(mw.a1));
                    check("wr_addr2", 64'(mem_addr2), 64'(mw.a2));
                    check("wr_din1", 64'(mem_din1), 64'(mw.d1));
                    check("wr_din2", 64'(mem_din2), 64'(mw.d2));
                end
            end
            if (stall_prev && out_valid) begin
                check("stall_d1", 64'(out_data1), 64'(prev_d1));
                check("stall_d2", 64'(out_data2), 64'(prev_d2));
                check("stall_two", 64'(out_two), 64'(prev_two));
                check("stall_last", 64'(out_last), 64'(prev_last));
            end
            stall_prev = out_valid && !out_ready;
            prev_d1 = out_data1;
            prev_d2 = out_data2;
            prev_two = out_two;
            prev_last = out_last;
            if (out_valid && out_ready) begin
                if (rd_q.size() == 0) flag("unexpected_pair");
                else begin
                    mr = rd_q.pop_front();
                    check("rd_d1", 64'(out_data1), 64'(mr.d1));
                    check("rd_d2", 64'(out_data2), 64'(mr.d2));
                    check("rd_two", 64'(out_two), 64'(mr.two));
                    check("rd_last", 64'(out_last), 64'(mr.last));
                end
            end
            if (done) begin
                if (done_q.size() == 0) flag("unexpected_done");
                else begin
                    mdone = done_q.pop_front();
                    check("done_err", 64'(err), 64'(mdone));
                end
            end else if (err) begin
                flag("err_without_done");
            end
        end
    end

    // Downstream readiness: 0 always ready, 1 random, 2 low three cycles out of four.
    int rmode = 0;
    int cyc = 0;
    always @(posedge clk) begin
        #1;
        cyc++;
        case (rmode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = ((cyc % 4) == 3);
        endcase
    end

    task automatic run_burst(input int base, input int len, input bit vrand,
                             input bit seq, input logic [DW-1:0] seed);
        logic [DW-1:0] w[$];
        int i;
        int budget;
        bit accepted;
        accepted = (len != 0) && (base + len <= SIZE);
        if (accepted) begin
            for (int j = 0; j < len; j++) w.push_back(seq ? seed + DW'(j) : DW'($urandom));
            for (int j = 0; j < len; j += 2) begin
                if (j + 1 < len) begin
                    wr_q.push_back('{AW'(base + j), AW'(base + j + 1), w[j], w[j + 1]});
                    rd_q.push_back('{w[j], w[j + 1], 1'b1, (j + 2 >= len)});
                end else begin
                    wr_q.push_back('{AW'(base + j), AW'(base + j), w[j], w[j]});
                    rd_q.push_back('{w[j], w[j], 1'b0, 1'b1});
                end
            end
            done_q.push_back(1'b0);
        end else begin
            done_q.push_back(len != 0);
        end
        @(posedge clk);
        #1;
        start = 1'b1;
        cfg_base = AW'(base);
        cfg_len = AW'(len);
        @(posedge clk);
        #1;
        start = 1'b0;
        if (!accepted) begin
            @(negedge clk);
            check("done_latency", 64'(done), 64'(1));
            check("err_latency", 64'(err), 64'(len != 0));
        end else begin
            i = 0;
            budget = 0;
            while (i < len && budget < 1000) begin
                in_valid = vrand ? 1'($urandom_range(0, 1)) : 1'b1;
                in_data = w[i];
                @(negedge clk);
                if (in_valid && in_ready) i++;
                @(posedge clk);
                #1;
                budget++;
            end
            in_valid = 1'b0;
            if (i < len) flag("fill_timeout");
        end
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (busy && budget < 2000);
        if (busy) flag("busy_timeout");
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        #23;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_mem_we", 64'(mem_we), 64'(0));
        check("rst_addr", 64'({mem_addr1, mem_addr2}), 64'(0));
        check("rst_din", 64'({mem_din1, mem_din2}), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        rmode = 0;
        run_burst(0, 4, 1'b0, 1'b1, 32'hA0);
        run_burst(10, 5, 1'b0, 1'b1, 32'd1);
        rmode = 2;
        run_burst(40, 4, 1'b1, 1'b0, '0);
        rmode = 0;
        run_burst(5, 0, 1'b0, 1'b0, '0);
        run_burst(298, 4, 1'b0, 1'b0, '0);

        // Abort a len=6 burst after one accepted word; nothing is queued for it.
        @(posedge clk);
        #1;
        start = 1'b1;
        cfg_base = AW'(20);
        cfg_len = AW'(6);
        @(posedge clk);
        #1;
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hDEAD;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_mem_we", 64'(mem_we), 64'(0));
        check("abort_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_burst(20, 2, 1'b0, 1'b0, '0);

        for (int n = 0; n < 40; n++) begin
            int b;
            int l;
            l = $urandom_range(0, 24);
            if ($urandom_range(0, 4) == 0) b = $urandom_range(SIZE - 20, SIZE - 1);
            else b = $urandom_range(0, SIZE - 24);
            rmode = $urandom_range(0, 2);
            run_burst(b, l, 1'($urandom_range(0, 1)), 1'b0, '0);
        end
        rmode = 0;
        repeat (3) @(negedge clk);

        check("left_writes", 64'(wr_q.size()), 64'(0));
        check("left_pairs", 64'(rd_q.size()), 64'(0));
        check("left_dones", 64'(done_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
